// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width default, the canonical RISC-V NOP
// and the {inst, addr} fetch entry layout used by the fetch path.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] inst;
    logic [XLEN_DEFAULT-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between IF, the prefetch queue and the IF/ID register.
// The slave modport is the queue itself; master is the fetch/decode side.
interface fetch_queue_if
  import cpu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            fetch_valid_i;
  logic [XLEN-1:0] fetch_inst_i;
  logic [XLEN-1:0] fetch_addr_i;
  logic            fetch_ready_o;
  logic            flush_i;
  logic            hold_flag_i;
  logic            inst_valid_o;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic [CW-1:0]   count_o;

  modport master (
    output fetch_valid_i, fetch_inst_i, fetch_addr_i, flush_i, hold_flag_i,
    input  fetch_ready_o, inst_valid_o, inst_o, inst_addr_o, count_o
  );

  modport slave (
    input  fetch_valid_i, fetch_inst_i, fetch_addr_i, flush_i, hold_flag_i,
    output fetch_ready_o, inst_valid_o, inst_o, inst_addr_o, count_o
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the prefetch queue: DEPTH x (2*XLEN) registers with one
// write port and one asynchronous read port. Contents carry no reset.
module fetch_queue_mem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [2*XLEN-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [2*XLEN-1:0]        rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [2*XLEN-1:0] mem_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == PW'(gi))) begin
        mem_q[gi] <= wr_data;
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between IF and IF/ID: circular buffer with flush
// and NOP bubble on empty. Define FETCH_QUEUE_BYPASS_EN for empty-queue forwarding.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(RV_NOP)
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave fq
);

  localparam int            PW         = $clog2(DEPTH);
  localparam int            CW         = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*XLEN-1:0] head_entry;
  logic              empty;
  logic              bypass_hit;
  logic              inst_valid;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              rd_adv;

  assign empty            = (count_q == '0);
  assign fq.fetch_ready_o = (count_q != FULL_COUNT) && !fq.flush_i;
  assign fq.count_o       = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = empty && fq.fetch_valid_i && !fq.flush_i;
`else
  assign bypass_hit = 1'b0;
`endif

  assign inst_valid = !empty || bypass_hit;
  assign push       = fq.fetch_valid_i && fq.fetch_ready_o;
  assign pop        = inst_valid && !fq.hold_flag_i && !fq.flush_i;
  // A forwarded entry consumed in the same cycle never touches the buffer.
  assign wr_en      = push && !(bypass_hit && pop);
  assign rd_adv     = pop && !bypass_hit;

  always_comb begin
    fq.inst_valid_o = inst_valid;
    fq.inst_o       = NOP_INST;
    fq.inst_addr_o  = '0;
    if (bypass_hit) begin
      fq.inst_o      = fq.fetch_inst_i;
      fq.inst_addr_o = fq.fetch_addr_i;
    end else if (!empty) begin
      fq.inst_o      = head_entry[2*XLEN-1:XLEN];
      fq.inst_addr_o = head_entry[XLEN-1:0];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fq.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data ({fq.fetch_inst_i, fq.fetch_addr_i}),
    .rd_addr (rd_ptr_q),
    .rd_data (head_entry)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): ordering, saturation, wrap, flush,
// asynchronous reset and the empty-queue path in either build.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq_if ();

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .NOP_INST (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input fetch_entry_t e);
    fq_if.fetch_valid_i = valid;
    fq_if.fetch_inst_i  = e.inst;
    fq_if.fetch_addr_i  = e.addr;
  endtask

  // One transaction line per clock: what was offered and what the head showed.
  task automatic tick();
    $display("t=%0t offer=%0b ready=%0b addr=%08h | head_valid=%0b inst=%08h addr=%08h hold=%0b flush=%0b count=%0d",
             $time, fq_if.fetch_valid_i, fq_if.fetch_ready_o, fq_if.fetch_addr_i,
             fq_if.inst_valid_o, fq_if.inst_o, fq_if.inst_addr_o,
             fq_if.hold_flag_i, fq_if.flush_i, fq_if.count_o);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fetch_entry_t e;
    rst                 = 1'b1;
    fq_if.flush_i       = 1'b0;
    fq_if.hold_flag_i   = 1'b0;
    e                   = '{inst: 32'h0, addr: 32'h0};
    drive(1'b0, e);

    // Reset values while reset is held
    #1 rst = 1'b0;
    #2;
    check("rst_count", fq_if.count_o, 0);
    check("rst_valid", fq_if.inst_valid_o, 0);
    check("rst_inst", fq_if.inst_o, NOP);
    check("rst_addr", fq_if.inst_addr_o, 0);
    @(posedge clk);
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    check("rst_ready", fq_if.fetch_ready_o, 1);
    tick();

    // Two instructions back to back, hold low
    drive(1'b1, '{inst: 32'h0050_0093, addr: 32'h0});
    tick();
    check("t1_valid0", fq_if.inst_valid_o, 1);
    check("t1_inst0", fq_if.inst_o, 32'h0050_0093);
    check("t1_addr0", fq_if.inst_addr_o, 32'h0);
    check("t1_count0", fq_if.count_o, 1);
    drive(1'b1, '{inst: 32'h00a0_0113, addr: 32'h4});
    tick();
    check("t1_inst1", fq_if.inst_o, 32'h00a0_0113);
    check("t1_addr1", fq_if.inst_addr_o, 32'h4);
    check("t1_count1", fq_if.count_o, 1);
    drive(1'b0, e);
    tick();
    check("t1_count_end", fq_if.count_o, 0);
    check("t1_valid_end", fq_if.inst_valid_o, 0);
    check("t1_nop_end", fq_if.inst_o, NOP);
    check("t1_addr_end", fq_if.inst_addr_o, 0);

    // Saturation under hold: five offers, four accepted
    fq_if.hold_flag_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, '{inst: 32'h1000_0000 + i, addr: 32'h40 + 4 * i});
      #1 check($sformatf("t2_ready%0d", i), fq_if.fetch_ready_o, 1);
      tick();
    end
    drive(1'b1, '{inst: 32'h1000_0004, addr: 32'h50});
    #1;
    check("t2_ready4", fq_if.fetch_ready_o, 0);
    check("t2_count_full", fq_if.count_o, 4);
    check("t2_head_held", fq_if.inst_addr_o, 32'h40);
    tick();
    check("t2_count_sat", fq_if.count_o, 4);
    drive(1'b0, e);
    fq_if.hold_flag_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain_inst%0d", i), fq_if.inst_o, 32'h1000_0000 + i);
      check($sformatf("t2_drain_addr%0d", i), fq_if.inst_addr_o, 32'h40 + 4 * i);
      tick();
    end
    check("t2_empty_valid", fq_if.inst_valid_o, 0);
    check("t2_empty_count", fq_if.count_o, 0);

    // Steady push+pop at occupancy 2, write pointer wrapping
    fq_if.hold_flag_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, '{inst: 32'h2000_0000 + i, addr: 4 * i});
      tick();
    end
    fq_if.hold_flag_i = 1'b0;
    for (int i = 2; i < 8; i++) begin
      drive(1'b1, '{inst: 32'h2000_0000 + i, addr: 4 * i});
      #1;
      check($sformatf("t3_count%0d", i), fq_if.count_o, 2);
      check($sformatf("t3_addr%0d", i), fq_if.inst_addr_o, 4 * (i - 2));
      check($sformatf("t3_inst%0d", i), fq_if.inst_o, 32'h2000_0000 + (i - 2));
      tick();
    end
    drive(1'b0, e);
    check("t3_addr_18", fq_if.inst_addr_o, 32'h18);
    check("t3_count_tail", fq_if.count_o, 2);
    tick();
    check("t3_addr_1c", fq_if.inst_addr_o, 32'h1C);
    check("t3_inst_1c", fq_if.inst_o, 32'h2000_0007);
    tick();
    check("t3_count_end", fq_if.count_o, 0);

    // Flush at occupancy 3 with an offer in the same cycle
    fq_if.hold_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, '{inst: 32'h3000_0000 + i, addr: 32'h80 + 4 * i});
      tick();
    end
    fq_if.flush_i = 1'b1;
    drive(1'b1, '{inst: 32'hDEAD_0000, addr: 32'h8C});
    #1;
    check("t4_ready_flush", fq_if.fetch_ready_o, 0);
    check("t4_count_pre", fq_if.count_o, 3);
    tick();
    fq_if.flush_i     = 1'b0;
    fq_if.hold_flag_i = 1'b0;
    drive(1'b0, e);
    check("t4_count_post", fq_if.count_o, 0);
    check("t4_valid_post", fq_if.inst_valid_o, 0);
    check("t4_nop_post", fq_if.inst_o, NOP);
    drive(1'b1, '{inst: 32'h0000_0513, addr: 32'h100});
    tick();
    drive(1'b0, e);
    check("t4_new_valid", fq_if.inst_valid_o, 1);
    check("t4_new_addr", fq_if.inst_addr_o, 32'h100);
    check("t4_new_inst", fq_if.inst_o, 32'h0000_0513);
    check("t4_new_count", fq_if.count_o, 1);
    tick();
    check("t4_count_end", fq_if.count_o, 0);

    // Asynchronous reset in the middle of a drain
    fq_if.hold_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, '{inst: 32'h4000_0000 + i, addr: 32'h200 + 4 * i});
      tick();
    end
    drive(1'b0, e);
    fq_if.hold_flag_i = 1'b0;
    tick();
    check("t5_count_mid", fq_if.count_o, 2);
    check("t5_addr_mid", fq_if.inst_addr_o, 32'h204);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_count", fq_if.count_o, 0);
    check("t5_rst_valid", fq_if.inst_valid_o, 0);
    check("t5_rst_inst", fq_if.inst_o, NOP);
    check("t5_rst_addr", fq_if.inst_addr_o, 0);
    check("t5_rst_ready", fq_if.fetch_ready_o, 1);
    #2 rst = 1'b1;
    tick();
    check("t5_after_count", fq_if.count_o, 0);
    check("t5_after_valid", fq_if.inst_valid_o, 0);

    // Offer into an empty queue: forwarded when bypass is built in, else 1-cycle latency
    fq_if.hold_flag_i = 1'b0;
    drive(1'b1, '{inst: 32'h0010_0073, addr: 32'h20});
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("t6_byp_valid", fq_if.inst_valid_o, 1);
    check("t6_byp_inst", fq_if.inst_o, 32'h0010_0073);
    check("t6_byp_addr", fq_if.inst_addr_o, 32'h20);
    tick();
    drive(1'b0, e);
    check("t6_byp_count", fq_if.count_o, 0);
    check("t6_byp_valid_after", fq_if.inst_valid_o, 0);
    fq_if.hold_flag_i = 1'b1;
    drive(1'b1, '{inst: 32'h0010_0073, addr: 32'h20});
    #1;
    check("t6_held_inst", fq_if.inst_o, 32'h0010_0073);
    tick();
    drive(1'b0, e);
    fq_if.hold_flag_i = 1'b0;
    check("t6_held_count", fq_if.count_o, 1);
    check("t6_held_head", fq_if.inst_o, 32'h0010_0073);
    tick();
    check("t6_held_drained", fq_if.count_o, 0);
`else
    check("t6_nobyp_valid", fq_if.inst_valid_o, 0);
    check("t6_nobyp_inst", fq_if.inst_o, NOP);
    tick();
    drive(1'b0, e);
    check("t6_nobyp_count", fq_if.count_o, 1);
    check("t6_nobyp_head", fq_if.inst_o, 32'h0010_0073);
    check("t6_nobyp_addr", fq_if.inst_addr_o, 32'h20);
    tick();
    check("t6_nobyp_drained", fq_if.count_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
